divider_unit: RTL
=================

// Module: divider_unit
// PURPOSE
//  Sequential unsigned restoring divider for the MIPS datapath (DIVU).
//  Computes one quotient bit per clock, then writes quotient to LO and remainder to HI.
//  Companion to the shift-add multiplier; shares the HI/LO readout convention.
//  The ALU control issues start and reads the result through dataOut (MFHI/MFLO).
// PARAMETERS
//  WIDTH  32  operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  reset        in   1        synchronous, active-high
//  start        in   1        divuOp: request a divide this cycle
//  dataA        in   WIDTH    dividend, sampled only on an accepted start
//  dataB        in   WIDTH    divisor, sampled only on an accepted start
//  readHi       in   1        1: dataOut=HI (MFHI), 0: dataOut=LO (MFLO)
//  busy         out  1        high while iterating (RUN)
//  done         out  1        one-cycle pulse: HI/LO just updated
//  divByZero    out  1        divisor of last completed divide was 0
//  hi           out  WIDTH    remainder of last completed divide
//  lo           out  WIDTH    quotient of last completed divide
//  dataOut      out  WIDTH    combinational mux: readHi ? hi : lo
// BEHAVIOUR
//  Reset (sync, highest priority):
//   - state=IDLE; busy=0, done=0, divByZero=0, hi=0, lo=0, counter=0.
//   - Overrides any edge, including mid-RUN: operation aborted, no result written.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE/DONE + start=1: latch dataA/dataB; rem=0 (WIDTH+1 b); quo=dataA; cnt=0; ->RUN.
//   - IDLE + start=0: stay IDLE.
//   - DONE + start=0: ->IDLE. Back-to-back start accepted in DONE.
//   - RUN: one restoring step per edge; cnt++.
//   - RUN, cnt==WIDTH-1 at edge: final step, then hi=rem, lo=quo, divByZero=(divisor==0); ->DONE.
//   - start while in RUN: ignored (no restart, no queueing).
//  Restoring step (divisor zero-extended to WIDTH+1 b):
//   - t = {rem[WIDTH-1:0], quo[WIDTH-1]}
//   - if t >= divisor: rem=t-divisor, quo={quo[WIDTH-2:0],1}
//   - else:            rem=t,         quo={quo[WIDTH-2:0],0}
//  Latency, start sampled at edge k:
//   - busy=1 after edges k..k+WIDTH-1.
//   - hi/lo/done update at edge k+WIDTH; done=1 for exactly one cycle.
//   - Total WIDTH+1 cycles start->done.
//  hi/lo hold their value until the next completed divide or reset; unchanged during RUN.
//  dataOut is valid any cycle, with no added latency.
//  Divide by zero: no special path; full latency.
//   - Result is the natural one: lo=all-ones, hi=dividend, divByZero=1.
//  divByZero updates only at completion. Input changes after the start edge do not affect the result.
// TESTING
//  100/7: start 1 cycle -> done 33 cycles later; lo=14, hi=2, divByZero=0; busy=1 for 32 cycles.
//  0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0; 3/10 -> lo=0, hi=3.
//  5/0 -> lo=0xFFFFFFFF, hi=5, divByZero=1, same 33-cycle latency.
//  Start 100/7, then pulse start 9/3 at RUN cycle 10 -> ignored; result 14/2. Then start during DONE -> 3/0, no idle gap.
//  Complete 100/7, then start 50/5 and assert reset at RUN cycle 5 -> next edge all outputs 0, IDLE; done never pulses.
//  readHi toggling at any time -> dataOut follows hi/lo the same cycle.

Source files
------------

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider (DIVU): one quotient bit per clock,
// quotient lands in LO and remainder in HI when the iteration finishes.
module divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             readHi,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // The partial remainder always ends below the divisor, so it fits in WIDTH
    // bits between steps; only the shifted trial value needs the extra bit.
    assign w_t       = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_t >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? WIDTH'(w_t - {1'b0, r_div}) : w_t[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_div   <= dataB;
                        r_quo   <= dataA;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_hi    <= w_rem_nxt;
                        r_lo    <= w_quo_nxt;
                        r_dbz   <= (r_div == '0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dataOut   = readHi ? r_hi : r_lo;
endmodule
